thermo_adc_reader: RTL

SPI master that periodically reads one 32-bit conversion frame from the thermocouple-to-digital converter on the `adc_*` pins. It decodes the frame into thermocouple temperature, cold-junction temperature and fault flags. It presents the decoded result to the host-facing SPI register stage with a single-cycle valid strobe. It is the stage directly upstream of the host SPI slave inside `tt_um_thermocouple`. It drives `adc_sck`/`adc_sce`/`adc_sout` and samples `adc_sin`.

---
 rtl/thermo_adc_reader.sv | 107 ++++++++++
 1 files changed

// File: rtl/thermo_adc_reader.sv
// SPI master that periodically reads one 32-bit frame from a thermocouple-to-digital
// converter and presents the decoded temperatures and fault flags with a valid strobe.
module thermo_adc_reader #(
  parameter int CLK_DIV  = 2,
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                start,
  input  logic [PERIOD_W-1:0] period,
  input  logic                adc_sin,
  output logic                adc_sck,
  output logic                adc_sce,
  output logic                adc_sout,
  output logic                busy,
  output logic                valid,
  output logic [13:0]         tc_temp,
  output logic [11:0]         cj_temp,
  output logic                fault,
  output logic [2:0]          fault_bits,
  output logic                frame_err
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;

  state_t              state, next_state;
  logic [7:0]          div_cnt;
  logic [5:0]          edge_cnt;
  logic                sck_q;
  logic [31:0]         shreg;
  logic [PERIOD_W-1:0] period_cnt;

  logic div_tick;
  logic period_expired;
  logic start_ok;
  logic in_frame;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_state     = state;
    div_tick       = (div_cnt == DIV_LAST);
    period_expired = (period_cnt == '0) && (period != '0);
    start_ok       = ena && (start || period_expired);
    in_frame       = (state == SHIFT) || (state == HOLD);
    case (state)
      IDLE:    if (start_ok) next_state = SHIFT;
      SHIFT:   if (div_tick && edge_cnt == 6'd63) next_state = HOLD;
      HOLD:    if (div_tick) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      edge_cnt   <= '0;
      sck_q      <= 1'b0;
      // NOTE: the shift register is reset too; it is cheap flops, not a RAM, and a clean
      // value keeps the decode path deterministic after reset.
      shreg      <= '0;
      period_cnt <= '0;
      tc_temp    <= '0;
      cj_temp    <= '0;
      fault      <= 1'b0;
      fault_bits <= '0;
      frame_err  <= 1'b0;
    end else begin
      state <= next_state;

      if (in_frame) div_cnt <= div_tick ? 8'd0 : div_cnt + 8'd1;
      else          div_cnt <= 8'd0;

      if (state == SHIFT && div_tick) begin
        sck_q    <= ~sck_q;
        edge_cnt <= edge_cnt + 6'd1;
        // Sample on the edge that raises SCK; the converter changes data on the fall.
        if (!sck_q) shreg <= {shreg[30:0], adc_sin};
      end

      // Load decoded fields on the edge entering DONE so they are visible with valid.
      if (state == HOLD && div_tick) begin
        tc_temp    <= shreg[31:18];
        cj_temp    <= shreg[15:4];
        fault      <= shreg[16];
        fault_bits <= shreg[2:0];
        frame_err  <= shreg[17] | shreg[3];
      end

      if (state == DONE)                         period_cnt <= period;
      else if (state == IDLE && period_cnt != '0) period_cnt <= period_cnt - 1'b1;
    end
  end

  assign adc_sck  = sck_q;
  assign adc_sce  = ~in_frame;
  assign adc_sout = 1'b0;
  assign busy     = (state != IDLE);
  assign valid    = (state == DONE);

endmodule
